// File: rtl/zports_pkg.sv
// Shared definitions for the Z80 port register bank: wait FSM states,
// shadow qualifier codes and the default port addresses.
package zports_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } wstate_e;

  // Per-channel shadow qualification codes
  localparam logic [1:0] SH_ALWAYS = 2'b00;
  localparam logic [1:0] SH_ON     = 2'b01;
  localparam logic [1:0] SH_OFF    = 2'b10;
  localparam logic [1:0] SH_NEVER  = 2'b11;

  // Default low port bytes
  localparam logic [7:0] PORTBF = 8'hBF;
  localparam logic [7:0] PORT77 = 8'h77;
  localparam logic [7:0] PORTF7 = 8'hF7;
  localparam logic [7:0] PORTEF = 8'hEF;

  function automatic logic shadow_ok(input logic [1:0] sel, input logic shadow);
    case (sel)
      SH_ALWAYS: return 1'b1;
      SH_ON:     return shadow;
      SH_OFF:    return ~shadow;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/zports_strobe.sv
// Z80 I/O cycle edge detector: samples IORQ&WR / IORQ&RD at Z80 clock
// rising edges and emits one fclk pulse per access.
module zports_strobe (
  input  logic fclk,
  input  logic rst,
  input  logic zpos,
  input  logic iorq_n,
  input  logic rd_n,
  input  logic wr_n,
  output logic wr_pulse,
  output logic rd_pulse
);

  logic ws0_q, ws1_q, rs0_q, rs1_q;
  logic wp_q, rp_q;

  // Two-stage edge detect; stage 0 only advances on zpos so glitches between
  // Z80 edges are ignored, stage 1 and the pulse run every fclk.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      ws0_q <= 1'b0;
      ws1_q <= 1'b0;
      rs0_q <= 1'b0;
      rs1_q <= 1'b0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
    end else begin
      if (zpos) begin
        ws0_q <= ~(iorq_n | wr_n);
        rs0_q <= ~(iorq_n | rd_n);
      end
      ws1_q <= ws0_q;
      rs1_q <= rs0_q;
      wp_q  <= ws0_q & ~ws1_q;
      rp_q  <= rs0_q & ~rs1_q;
    end
  end

  assign wr_pulse = wp_q;
  assign rd_pulse = rp_q;

endmodule

// File: rtl/zports_bank.sv
// Parametrised fclk-domain Z80 port register bank with shadow-qualified
// decode, per-channel strobes and a wait handshake for slow agents.
module zports_bank
  import zports_pkg::*;
#(
  parameter int                NCH        = 4,
  parameter logic [NCH*8-1:0]  PORT_ADDRS = {PORTEF, PORTF7, PORT77, PORTBF},
  parameter logic [NCH*8-1:0]  RST_VALS   = '0,
  parameter logic [NCH*2-1:0]  SHADOW_SEL = '0,
  parameter logic [NCH-1:0]    WAIT_MASK  = '0,
  parameter int                WAIT_TMO   = 255
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             zpos,
  input  logic             iorq_n,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic [15:0]      a,
  input  logic [7:0]       din,
  input  logic             shadow,
  output logic             porthit,
  output logic [7:0]       dout,
  output logic             dataout,
  output logic [NCH*8-1:0] regs,
  output logic [NCH-1:0]   wr_stb,
  output logic [NCH-1:0]   rd_stb,
  output logic             z_wait_n,
  output logic             wait_req,
  output logic [3:0]       wait_ch,
  output logic             wait_rnw,
  output logic [7:0]       wait_wdata,
  input  logic             wait_ack,
  input  logic [7:0]       wait_rdata,
  output logic             tmo_flag
);

  localparam int            CW    = $clog2(WAIT_TMO + 1);
  localparam logic [CW-1:0] TMO_V = CW'(WAIT_TMO);

  logic                   wr_pulse, rd_pulse;
  logic [NCH-1:0]         match, sel_oh;
  logic [3:0]             hit_idx;
  logic                   hit_wait, start;
  logic [7:0]             hit_val;
  logic [NCH-1:0][7:0]    regs_q;
  logic [7:0]             rdata_q, wdata_q;
  logic [3:0]             ch_q;
  logic                   rnw_q, tmo_q;
  logic [CW-1:0]          cnt_q;
  wstate_e                state_q, state_d;

  // Only the low address byte is decoded
  logic unused_ahi;
  assign unused_ahi = ^a[15:8];

  zports_strobe u_stb (
    .fclk     (fclk),
    .rst      (rst),
    .zpos     (zpos),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .wr_pulse (wr_pulse),
    .rd_pulse (rd_pulse)
  );

  // Per-channel address + shadow match
  always_comb begin
    match = '0;
    for (int i = 0; i < NCH; i++)
      match[i] = (a[7:0] == PORT_ADDRS[i*8 +: 8]) && shadow_ok(SHADOW_SEL[i*2 +: 2], shadow);
  end

  // Priority select: scan downwards so the lowest matching index wins
  always_comb begin
    sel_oh   = '0;
    hit_idx  = '0;
    hit_wait = 1'b0;
    hit_val  = 8'hFF;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        hit_idx   = 4'(i);
        hit_wait  = WAIT_MASK[i];
        hit_val   = regs_q[i];
      end
    end
  end

  assign porthit = |match;
  assign dout    = !porthit ? 8'hFF : (hit_wait ? rdata_q : hit_val);
  assign dataout = porthit & ~iorq_n & ~rd_n;
  assign wr_stb  = sel_oh & {NCH{wr_pulse}};
  assign rd_stb  = sel_oh & {NCH{rd_pulse}};
  assign regs    = regs_q;

  // A strobe on a wait channel only opens a handshake when the FSM is free
  assign start = (state_q == ST_IDLE) && hit_wait && (wr_pulse || rd_pulse);

  // Wait FSM state register
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Wait FSM next state; ack has priority over timeout in REQ
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ:  if (wait_ack || cnt_q == TMO_V) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait FSM outputs; WAIT drops combinationally with the opening strobe
  always_comb begin
    wait_req = (state_q == ST_REQ);
    z_wait_n = !((state_q == ST_REQ) || start);
  end

  // Register array, request latches, timeout counter and read-data latch
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      regs_q  <= RST_VALS;
      rdata_q <= 8'hFF;
      wdata_q <= 8'h00;
      ch_q    <= 4'd0;
      rnw_q   <= 1'b1;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_stb[i] && !WAIT_MASK[i])
          regs_q[i] <= din;
        if (state_q == ST_REQ && wait_ack && !rnw_q && ch_q == 4'(i))
          regs_q[i] <= wdata_q;
      end
      if (start) begin
        ch_q    <= hit_idx;
        rnw_q   <= rd_pulse;
        wdata_q <= din;
        cnt_q   <= '0;
      end else if (state_q == ST_REQ) begin
        if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
        if (wait_ack) begin
          if (rnw_q) rdata_q <= wait_rdata;
        end else if (cnt_q == TMO_V) begin
          rdata_q <= 8'hFF;
          tmo_q   <= 1'b1;
        end
      end
    end
  end

  assign wait_ch    = ch_q;
  assign wait_rnw   = rnw_q;
  assign wait_wdata = wdata_q;
  assign tmo_flag   = tmo_q;

endmodule
